// File: rtl/ed_winner_select.sv
// rtl/ed_winner_select.sv - serial nearest / second-nearest node search over streamed distances
module ed_winner_select #(
    parameter int NODE_IDX_W = 8,
    parameter int ED_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  ed_valid,
    output logic                  ed_ready,
    input  logic [ED_W-1:0]       ed,
    input  logic [NODE_IDX_W-1:0] node_idx,
    input  logic                  last,
    output logic                  busy,
    output logic                  done,
    output logic [NODE_IDX_W-1:0] win_idx,
    output logic [ED_W-1:0]       win_ed,
    output logic [NODE_IDX_W-1:0] sec_idx,
    output logic [ED_W-1:0]       sec_ed,
    output logic                  sec_valid,
    output logic [NODE_IDX_W:0]   node_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Largest representable search size: 2^NODE_IDX_W nodes.
    localparam logic [NODE_IDX_W:0] COUNT_MAX = {1'b1, {NODE_IDX_W{1'b0}}};

    state_t                  state_q, state_d;
    logic                    win_found_q, win_found_d;
    logic                    sec_valid_q, sec_valid_d;
    logic [NODE_IDX_W-1:0]   win_idx_q, win_idx_d;
    logic [ED_W-1:0]         win_ed_q, win_ed_d;
    logic [NODE_IDX_W-1:0]   sec_idx_q, sec_idx_d;
    logic [ED_W-1:0]         sec_ed_q, sec_ed_d;
    logic [NODE_IDX_W:0]     node_count_q, node_count_d;

    // Handshake and status flags depend on state only, so no input reaches an output combinationally.
    assign ed_ready   = (state_q == S_SEARCH);
    assign busy       = (state_q == S_SEARCH);
    assign done       = (state_q == S_DONE);
    assign win_idx    = win_idx_q;
    assign win_ed     = win_ed_q;
    assign sec_idx    = sec_idx_q;
    assign sec_ed     = sec_ed_q;
    assign sec_valid  = sec_valid_q;
    assign node_count = node_count_q;

    // Next-state and tracking update; start takes priority so a sample beside it is dropped.
    always_comb begin
        state_d      = state_q;
        win_found_d  = win_found_q;
        sec_valid_d  = sec_valid_q;
        win_idx_d    = win_idx_q;
        win_ed_d     = win_ed_q;
        sec_idx_d    = sec_idx_q;
        sec_ed_d     = sec_ed_q;
        node_count_d = node_count_q;

        if (start) begin
            state_d      = S_SEARCH;
            win_found_d  = 1'b0;
            sec_valid_d  = 1'b0;
            win_idx_d    = '0;
            win_ed_d     = '1;
            sec_idx_d    = '0;
            sec_ed_d     = '1;
            node_count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_SEARCH: begin
                    if (ed_valid) begin
                        if (node_count_q != COUNT_MAX) begin
                            node_count_d = node_count_q + (NODE_IDX_W+1)'(1);
                        end
                        // Strict compares keep the earlier node ahead on ties; the
                        // found/valid flags make all-ones distances ordinary values.
                        if (!win_found_q) begin
                            win_found_d = 1'b1;
                            win_idx_d   = node_idx;
                            win_ed_d    = ed;
                        end else if (ed < win_ed_q) begin
                            sec_valid_d = 1'b1;
                            sec_idx_d   = win_idx_q;
                            sec_ed_d    = win_ed_q;
                            win_idx_d   = node_idx;
                            win_ed_d    = ed;
                        end else if (!sec_valid_q || (ed < sec_ed_q)) begin
                            sec_valid_d = 1'b1;
                            sec_idx_d   = node_idx;
                            sec_ed_d    = ed;
                        end
                        if (last) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and result registers; asynchronous reset discards any search in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            win_found_q  <= 1'b0;
            sec_valid_q  <= 1'b0;
            win_idx_q    <= '0;
            win_ed_q     <= '1;
            sec_idx_q    <= '0;
            sec_ed_q     <= '1;
            node_count_q <= '0;
        end else begin
            state_q      <= state_d;
            win_found_q  <= win_found_d;
            sec_valid_q  <= sec_valid_d;
            win_idx_q    <= win_idx_d;
            win_ed_q     <= win_ed_d;
            sec_idx_q    <= sec_idx_d;
            sec_ed_q     <= sec_ed_d;
            node_count_q <= node_count_d;
        end
    end

endmodule

// File: tb/tb_ed_winner_select.sv
// tb/tb_ed_winner_select.sv - self-checking bench for ed_winner_select
module tb_ed_winner_select;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ed_valid;
    logic        ed_ready;
    logic [31:0] ed;
    logic [7:0]  node_idx;
    logic        last;
    logic        busy;
    logic        done;
    logic [7:0]  win_idx;
    logic [31:0] win_ed;
    logic [7:0]  sec_idx;
    logic [31:0] sec_ed;
    logic        sec_valid;
    logic [8:0]  node_count;

    int checks;
    int errors;

    ed_winner_select #(.NODE_IDX_W(8), .ED_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ed_valid   (ed_valid),
        .ed_ready   (ed_ready),
        .ed         (ed),
        .node_idx   (node_idx),
        .last       (last),
        .busy       (busy),
        .done       (done),
        .win_idx    (win_idx),
        .win_ed     (win_ed),
        .sec_idx    (sec_idx),
        .sec_ed     (sec_ed),
        .sec_valid  (sec_valid),
        .node_count (node_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [3:0][31:0] eds;
        logic [3:0][7:0]  idxs;
        logic [7:0]      e_win_idx;
        logic [31:0]     e_win_ed;
        logic [7:0]      e_sec_idx;
        logic [31:0]     e_sec_ed;
        logic            e_sec_valid;
        logic [8:0]      e_count;
    } vec_t;

    vec_t vecs[6];

    logic [31:0] q_ed[$];
    logic [7:0]  q_idx[$];

    logic [7:0]  m_win_idx;
    logic [31:0] m_win_ed;
    logic [7:0]  m_sec_idx;
    logic [31:0] m_sec_ed;
    logic        m_sec_valid;
    logic [8:0]  m_count;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: results are the first two entries of the accepted list ordered by
    // distance, with equal distances kept in arrival order.
    task automatic model();
        int n;
        int p1;
        int p2;
        logic [31:0] min1;
        logic [31:0] min2;
        n = q_ed.size();
        m_count = (n > 256) ? 9'd256 : 9'(n);
        m_win_idx = 8'd0; m_win_ed = '1;
        m_sec_idx = 8'd0; m_sec_ed = '1; m_sec_valid = 1'b0;
        if (n == 0) return;
        min1 = q_ed[0];
        foreach (q_ed[i]) if (q_ed[i] < min1) min1 = q_ed[i];
        p1 = -1;
        foreach (q_ed[i]) if (p1 < 0 && q_ed[i] == min1) p1 = i;
        m_win_idx = q_idx[p1];
        m_win_ed  = min1;
        if (n < 2) return;
        min2 = '1;
        foreach (q_ed[i]) if (i != p1 && q_ed[i] < min2) min2 = q_ed[i];
        p2 = -1;
        foreach (q_ed[i]) if (p2 < 0 && i != p1 && q_ed[i] == min2) p2 = i;
        m_sec_idx = q_idx[p2];
        m_sec_ed = min2;
        m_sec_valid = 1'b1;
    endtask

    // Starts a search and streams the queued samples; returns in the DONE cycle.
    task automatic feed_search(input bit gaps);
        start = 1'b1; ed_valid = 1'b0; last = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < q_ed.size(); i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                    ed_valid = 1'b0; ed = $urandom; node_idx = 8'($urandom);
                    step();
                end
            end
            ed_valid = 1'b1; ed = q_ed[i]; node_idx = q_idx[i];
            last = (i == q_ed.size() - 1);
            step();
        end
        ed_valid = 1'b0; last = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [7:0] wi, input logic [31:0] we,
                             input logic [7:0] si, input logic [31:0] se, input logic sv,
                             input logic [8:0] cnt);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_win_idx"}, 64'(win_idx), 64'(wi));
        chk({tag, "_win_ed"}, 64'(win_ed), 64'(we));
        chk({tag, "_sec_idx"}, 64'(sec_idx), 64'(si));
        chk({tag, "_sec_ed"}, 64'(sec_ed), 64'(se));
        chk({tag, "_sec_valid"}, 64'(sec_valid), 64'(sv));
        chk({tag, "_count"}, 64'(node_count), 64'(cnt));
    endtask

    task automatic load_vec(input int k);
        q_ed.delete(); q_idx.delete();
        for (int i = 0; i < vecs[k].n; i++) begin
            q_ed.push_back(vecs[k].eds[i]);
            q_idx.push_back(vecs[k].idxs[i]);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; ed_valid = 1'b0; ed = '0; node_idx = '0; last = 1'b0;

        vecs[0] = '{4, {32'd30, 32'd70, 32'd20, 32'd50}, {8'd3, 8'd2, 8'd1, 8'd0},
                    8'd1, 32'd20, 8'd3, 32'd30, 1'b1, 9'd4};
        vecs[1] = '{1, {32'd0, 32'd0, 32'd0, 32'd9}, {8'd0, 8'd0, 8'd0, 8'd5},
                    8'd5, 32'd9, 8'd0, 32'hFFFF_FFFF, 1'b0, 9'd1};
        vecs[2] = '{3, {32'd0, 32'd10, 32'd10, 32'd10}, {8'd0, 8'd2, 8'd1, 8'd0},
                    8'd0, 32'd10, 8'd1, 32'd10, 1'b1, 9'd3};
        vecs[3] = '{3, {32'd0, 32'd20, 32'd30, 32'd40}, {8'd0, 8'd2, 8'd1, 8'd0},
                    8'd2, 32'd20, 8'd1, 32'd30, 1'b1, 9'd3};
        vecs[4] = '{2, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, {8'd0, 8'd0, 8'd1, 8'd0},
                    8'd1, 32'd0, 8'd0, 32'hFFFF_FFFF, 1'b1, 9'd2};
        vecs[5] = '{2, {32'd0, 32'd0, 32'd3, 32'd7}, {8'd0, 8'd0, 8'd6, 8'd4},
                    8'd6, 32'd3, 8'd4, 32'd7, 1'b1, 9'd2};

        #12;
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_ready", 64'(ed_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sec_valid", 64'(sec_valid), 64'd0);
        chk("rst_win_ed", 64'(win_ed), 64'hFFFF_FFFF);
        chk("rst_sec_ed", 64'(sec_ed), 64'hFFFF_FFFF);
        chk("rst_win_idx", 64'(win_idx), 64'd0);
        chk("rst_count", 64'(node_count), 64'd0);

        // Directed table
        for (int k = 0; k < 6; k++) begin
            load_vec(k);
            feed_search(1'b0);
            check_res($sformatf("vec%0d", k), vecs[k].e_win_idx, vecs[k].e_win_ed,
                      vecs[k].e_sec_idx, vecs[k].e_sec_ed, vecs[k].e_sec_valid, vecs[k].e_count);
            step();
            chk($sformatf("vec%0d_done_clr", k), 64'(done), 64'd0);
            chk($sformatf("vec%0d_hold", k), 64'(win_idx), 64'(vecs[k].e_win_idx));
        end

        // ed_valid in IDLE is ignored
        ed_valid = 1'b1; ed = 32'd0; node_idx = 8'd99; last = 1'b1;
        step(); step(); step();
        chk("idle_ign_count", 64'(node_count), 64'd2);
        chk("idle_ign_win", 64'(win_idx), 64'd6);
        chk("idle_ign_busy", 64'(busy), 64'd0);
        chk("idle_ign_done", 64'(done), 64'd0);
        ed_valid = 1'b0; last = 1'b0;

        // ed_valid held through the DONE cycle is ignored
        load_vec(0);
        feed_search(1'b0);
        ed_valid = 1'b1; ed = 32'd1; node_idx = 8'd77; last = 1'b1;
        chk("done_ign_pulse", 64'(done), 64'd1);
        step();
        chk("done_ign_count", 64'(node_count), 64'd4);
        chk("done_ign_win", 64'(win_idx), 64'd1);
        chk("done_ign_state", 64'(busy), 64'd0);
        ed_valid = 1'b0; last = 1'b0;

        // Restart mid-search; the sample beside start is dropped
        start = 1'b1; step(); start = 1'b0;
        ed_valid = 1'b1; ed = 32'd100; node_idx = 8'd1; step();
        ed = 32'd1; node_idx = 8'd2; step();
        start = 1'b1; ed = 32'd0; node_idx = 8'd9; step();
        start = 1'b0; ed_valid = 1'b0;
        chk("restart_count", 64'(node_count), 64'd0);
        chk("restart_win_ed", 64'(win_ed), 64'hFFFF_FFFF);
        chk("restart_busy", 64'(busy), 64'd1);
        ed_valid = 1'b1; ed = 32'd7; node_idx = 8'd4; step();
        ed = 32'd3; node_idx = 8'd6; last = 1'b1; step();
        ed_valid = 1'b0; last = 1'b0;
        check_res("restart", 8'd6, 32'd3, 8'd4, 32'd7, 1'b1, 9'd2);

        // start in the DONE cycle goes straight back to SEARCH
        start = 1'b1; step(); start = 1'b0;
        chk("done_start_busy", 64'(busy), 64'd1);
        chk("done_start_done", 64'(done), 64'd0);
        chk("done_start_count", 64'(node_count), 64'd0);
        chk("done_start_sv", 64'(sec_valid), 64'd0);
        ed_valid = 1'b1; ed = 32'd5; node_idx = 8'd8; last = 1'b1; step();
        ed_valid = 1'b0; last = 1'b0;
        check_res("done_start", 8'd8, 32'd5, 8'd0, 32'hFFFF_FFFF, 1'b0, 9'd1);
        step();

        // Randomized searches against the reference model
        for (int t = 0; t < 40; t++) begin
            int n;
            bit narrow;
            n = $urandom_range(1, 12);
            narrow = $urandom_range(0, 1);
            q_ed.delete(); q_idx.delete();
            for (int i = 0; i < n; i++) begin
                q_ed.push_back(narrow ? 32'($urandom_range(0, 7)) : 32'($urandom));
                q_idx.push_back(8'($urandom));
            end
            if ($urandom_range(0, 9) == 0) q_ed[0] = 32'hFFFF_FFFF;
            model();
            feed_search(1'b1);
            check_res($sformatf("rand%0d", t), m_win_idx, m_win_ed, m_sec_idx, m_sec_ed,
                      m_sec_valid, m_count);
            step();
        end

        // node_count saturation over a long search
        q_ed.delete(); q_idx.delete();
        for (int i = 0; i < 300; i++) begin
            q_ed.push_back(32'($urandom_range(0, 100000)));
            q_idx.push_back(8'(i));
        end
        model();
        feed_search(1'b0);
        check_res("sat", m_win_idx, m_win_ed, m_sec_idx, m_sec_ed, m_sec_valid, m_count);
        step();

        // Asynchronous reset mid-search
        start = 1'b1; step(); start = 1'b0;
        ed_valid = 1'b1; ed = 32'd4; node_idx = 8'd3; step();
        ed = 32'd2; node_idx = 8'd4; step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ready", 64'(ed_ready), 64'd0);
        chk("arst_count", 64'(node_count), 64'd0);
        chk("arst_win_ed", 64'(win_ed), 64'hFFFF_FFFF);
        chk("arst_win_idx", 64'(win_idx), 64'd0);
        chk("arst_sec_valid", 64'(sec_valid), 64'd0);
        last = 1'b1;
        step();
        #3;
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                step();
                if (done) seen++;
            end
            chk("arst_no_done", 64'(seen), 64'd0);
        end
        chk("arst_idle_count", 64'(node_count), 64'd0);
        ed_valid = 1'b0; last = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ed_winner_select.md
# ed_winner_select

Sequential best-match search stage directly downstream of the Euclidean-distance calculator. For one input vector it consumes one distance per node, serially, and tracks the nearest node (winner) and the second-nearest node (runner-up). It reports both indices and distances with a one-cycle `done` pulse. Its results feed the node-update and edge/insertion logic of the GAM network.

## Interface
- `NODE_IDX_W`, default 8: width of node index; up to 2^NODE_IDX_W nodes per search.
- `ED_W`, default 32: width of distance values; matches the calculator's 32-bit ED output.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new search; clears all tracking state.
- `ed_valid`  in  1  `ed`/`node_idx`/`last` valid this cycle.
- `ed_ready`  out  1  stage accepts a distance this cycle; high only in SEARCH.
- `ed`  in  ED_W  distance from calculator (unsigned).
- `node_idx`  in  NODE_IDX_W  index of node whose distance is presented.
- `last`  in  1  qualifies final distance of the search.
- `busy`  out  1  high in SEARCH.
- `done`  out  1  one-cycle pulse: results valid.
- `win_idx`  out  NODE_IDX_W  index of smallest distance.
- `win_ed`  out  ED_W  smallest distance.
- `sec_idx`  out  NODE_IDX_W  index of second-smallest distance.
- `sec_ed`  out  ED_W  second-smallest distance.
- `sec_valid`  out  1  runner-up exists (≥2 distances accepted).
- `node_count`  out  NODE_IDX_W+1  distances accepted in current/last search.

## Operation
- States: IDLE, SEARCH, DONE.
  - IDLE → SEARCH on `start`.
  - SEARCH → DONE on accepted sample with `last`=1.
  - DONE → IDLE unconditionally after one cycle. If `start` is high in DONE, go directly to SEARCH.
- Accept = `ed_valid && ed_ready`. `ed_valid` outside SEARCH is ignored with no state change.
- On `start`, from any state: clear `win_found`, `sec_valid`, `node_count`. Set `win_ed`/`sec_ed` to all-ones and indices to 0. Enter SEARCH.
- `start` in SEARCH aborts the current search and restarts. A sample presented in the same cycle as `start` is not accepted (`ed_ready` refers to the current state; the clear wins).
- Update on accept, using unsigned compares:
  - No winner yet: winner ← sample.
  - `ed < win_ed`: runner-up ← old winner, `sec_valid` ← 1, winner ← sample.
  - Else if `!sec_valid` or `ed < sec_ed`: runner-up ← sample, `sec_valid` ← 1.
  - Else: no change.
- Ties are resolved by strict less-than, so the earlier-presented node keeps its rank. An `ed` equal to `win_ed` becomes runner-up if it beats the current runner-up.
- `node_count` increments per accept and saturates at 2^NODE_IDX_W.
- All-ones distances are legal and handled by the found/valid flags, not by sentinel compares.
- Indices are taken from `node_idx` as given. Non-sequential or duplicate indices are not checked.

## Timing
- Reset values: state IDLE; `ed_ready`, `busy`, `done`, `sec_valid` = 0; `win_ed`, `sec_ed` = all-ones; `win_idx`, `sec_idx` = 0; `node_count` = 0.
- Reset mid-search discards everything; no `done` is issued.
- Throughput: one distance per cycle in SEARCH.
- Latency: the tracking registers update on the edge that accepts the sample.
- `done` is asserted in the cycle after the `last` sample is accepted; the results already include that sample.
- Results hold stable from `done` until the next `start` or reset.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Test plan
- Reset, then `start`, then 4 samples idx 0..3 with ed 50, 20, 70, 30 (`last` on idx 3) → `done` one cycle after idx 3; win 1/20, sec 3/30, `sec_valid`=1, `node_count`=4.
- Single sample idx 5, ed 9, `last`=1 → win 5/9, `sec_valid`=0, `sec_ed`=FFFFFFFF, `node_count`=1.
- Ties: idx 0..2 all ed 10 → win 0/10, sec 1/10. Then descending 40, 30, 20 → win idx 2, sec idx 1 (displaced winner moves to runner-up).
- Edge values: ed FFFFFFFF then 0 → win idx of 0, sec FFFFFFFF with `sec_valid`=1. `ed_valid` pulses in IDLE/DONE → ignored, counts unchanged.
- Restart: `start` asserted again after 2 samples, then 2 new samples 7, 3 → results reflect only 7, 3; `node_count`=2. `start` in the DONE cycle → SEARCH next cycle with no IDLE cycle.
- `rst_n` low mid-search (async, between edges) → outputs immediately at reset values; no `done` pulse afterwards.
